// File: rtl/nn_pkg.sv
// Shared types and constants for the fully connected network sequencer.
// Also holds the index-width helpers used to size the address ports.
package nn_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_MAC,
        S_WR,
        S_ARGMAX,
        S_REPORT
    } state_t;

    localparam int DEF_NUM_SAMPLES = 750;
    localparam int DEF_NUM_INPUTS  = 62;
    localparam int DEF_NUM_HIDDEN  = 30;
    localparam int DEF_NUM_OUTPUTS = 10;
    localparam int DEF_PE_COUNT    = 10;
    localparam int DEF_SCORE_W     = 16;

    // Width of an index over n items; never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nn_argmax.sv
// Running signed maximum over a stream of output scores.
// The winner including the current score is visible combinationally on best_idx.
module nn_argmax
    import nn_pkg::*;
#(
    parameter int SCORE_W = DEF_SCORE_W,
    parameter int IDX_W   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      seed,
    input  logic                      step,
    input  logic                      finish,
    input  logic [IDX_W-1:0]          idx,
    input  logic signed [SCORE_W-1:0] score,
    output logic [IDX_W-1:0]          best_idx
);

    logic signed [SCORE_W-1:0] max_val;
    logic [IDX_W-1:0]          max_idx;
    logic                      take;

    // NOTE: every signal written in always_comb gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        take     = seed || (score > max_val);
        best_idx = take ? idx : max_idx;
    end

    // Strict greater-than keeps the earlier index on ties.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_val <= '0;
            max_idx <= '0;
        end else if (finish) begin
            max_val <= '0;
            max_idx <= '0;
        end else if (step) begin
            if (take) begin
                max_val <= score;
            end
            max_idx <= best_idx;
        end
    end

endmodule

// File: rtl/nn_sequencer.sv
// Sequencer for the fully connected network: steps each sample through the hidden
// and output layers on a shared PE bank, then reports the argmax class per sample.
module nn_sequencer
    import nn_pkg::*;
#(
    parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
    parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
    parameter int NUM_HIDDEN  = DEF_NUM_HIDDEN,
    parameter int NUM_OUTPUTS = DEF_NUM_OUTPUTS,
    parameter int PE_COUNT    = DEF_PE_COUNT,
    parameter int SCORE_W     = DEF_SCORE_W
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    output logic [idx_w(NUM_SAMPLES)-1:0]                 sample_idx,
    output logic                                          layer_sel,
    output logic [idx_w(NUM_HIDDEN)-1:0]                  neuron_base,
    output logic [idx_w(max_i(NUM_INPUTS, NUM_HIDDEN))-1:0] in_idx,
    output logic                                          mac_clr,
    output logic                                          mac_en,
    output logic                                          act_wr,
    output logic [idx_w(NUM_OUTPUTS)-1:0]                 score_idx,
    input  logic signed [SCORE_W-1:0]                     score,
    output logic [7:0]                                    result,
    output logic                                          batch_done,
    output logic                                          done,
    output logic                                          busy
);

    localparam int SA_W = idx_w(NUM_SAMPLES);
    localparam int NB_W = idx_w(NUM_HIDDEN);
    localparam int IN_W = idx_w(max_i(NUM_INPUTS, NUM_HIDDEN));
    localparam int SC_W = idx_w(NUM_OUTPUTS);

    state_t state;
    state_t state_nxt;

    logic mac_last;
    logic more_hidden;
    logic score_last;
    logic sample_last;
    logic am_seed;
    logic am_step;
    logic am_finish;
    logic [SC_W-1:0] best_idx;

    // Fan-in depends on which layer the PEs are currently evaluating.
    assign mac_last    = layer_sel ? (in_idx == IN_W'(NUM_HIDDEN - 1))
                                   : (in_idx == IN_W'(NUM_INPUTS - 1));
    assign more_hidden = (int'(neuron_base) + PE_COUNT) < NUM_HIDDEN;
    assign score_last  = (score_idx == SC_W'(NUM_OUTPUTS - 1));
    assign sample_last = (sample_idx == SA_W'(NUM_SAMPLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_CLR;
            S_CLR:    state_nxt = S_MAC;
            S_MAC:    if (mac_last) state_nxt = S_WR;
            S_WR:     state_nxt = layer_sel ? S_ARGMAX : S_CLR;
            S_ARGMAX: if (score_last) state_nxt = S_REPORT;
            S_REPORT: state_nxt = sample_last ? S_IDLE : S_CLR;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mac_clr    = 1'b0;
        mac_en     = 1'b0;
        act_wr     = 1'b0;
        batch_done = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_CLR:    mac_clr    = 1'b1;
            S_MAC:    mac_en     = 1'b1;
            S_WR:     act_wr     = 1'b1;
            S_REPORT: batch_done = 1'b1;
            default:  ;
        endcase
    end

    assign am_step   = (state == S_ARGMAX);
    assign am_seed   = am_step && (score_idx == '0);
    assign am_finish = am_step && score_last;

    nn_argmax #(
        .SCORE_W (SCORE_W),
        .IDX_W   (SC_W)
    ) u_argmax (
        .clk      (clk),
        .rst      (rst),
        .seed     (am_seed),
        .step     (am_step),
        .finish   (am_finish),
        .idx      (score_idx),
        .score    (score),
        .best_idx (best_idx)
    );

    // Counters and report registers. result and done load on the edge into
    // REPORT so they are valid during the batch_done cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_idx  <= '0;
            layer_sel   <= 1'b0;
            neuron_base <= '0;
            in_idx      <= '0;
            score_idx   <= '0;
            result      <= '0;
            done        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sample_idx  <= '0;
                        layer_sel   <= 1'b0;
                        neuron_base <= '0;
                        in_idx      <= '0;
                        score_idx   <= '0;
                        done        <= 1'b0;
                    end
                end
                S_CLR: begin
                    in_idx <= '0;
                end
                S_MAC: begin
                    in_idx <= mac_last ? '0 : in_idx + 1'b1;
                end
                S_WR: begin
                    if (layer_sel) begin
                        score_idx <= '0;
                    end else if (more_hidden) begin
                        neuron_base <= neuron_base + NB_W'(PE_COUNT);
                    end else begin
                        layer_sel   <= 1'b1;
                        neuron_base <= '0;
                    end
                end
                S_ARGMAX: begin
                    if (score_last) begin
                        score_idx <= '0;
                        result    <= 8'(best_idx);
                        if (sample_last) begin
                            done <= 1'b1;
                        end
                    end else begin
                        score_idx <= score_idx + 1'b1;
                    end
                end
                S_REPORT: begin
                    layer_sel   <= 1'b0;
                    neuron_base <= '0;
                    if (!sample_last) begin
                        sample_idx <= sample_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_sequencer.sv
// Self-checking bench: a small configuration traced cycle by cycle, plus a
// default-dimension instance checked against a latency/argmax scoreboard.
module tb_nn_sequencer;
    import nn_pkg::*;

    localparam int S_NS = 2, S_NI = 4, S_NH = 3, S_NO = 3, S_PE = 2;
    localparam int D_NS = 6, D_NI = 62, D_NH = 30, D_NO = 10, D_PE = 10;
    localparam int SW = 16;

    localparam int S_SA_W = idx_w(S_NS);
    localparam int S_NB_W = idx_w(S_NH);
    localparam int S_IN_W = idx_w(max_i(S_NI, S_NH));
    localparam int S_SC_W = idx_w(S_NO);
    localparam int D_SA_W = idx_w(D_NS);
    localparam int D_NB_W = idx_w(D_NH);
    localparam int D_IN_W = idx_w(max_i(D_NI, D_NH));
    localparam int D_SC_W = idx_w(D_NO);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Small instance
    logic              s_start = 1'b0;
    logic [S_SA_W-1:0] s_sample_idx;
    logic              s_layer_sel;
    logic [S_NB_W-1:0] s_neuron_base;
    logic [S_IN_W-1:0] s_in_idx;
    logic              s_mac_clr, s_mac_en, s_act_wr;
    logic [S_SC_W-1:0] s_score_idx;
    logic signed [SW-1:0] s_score;
    logic [7:0]        s_result;
    logic              s_batch_done, s_done, s_busy;

    // Default-dimension instance
    logic              d_start = 1'b0;
    logic [D_SA_W-1:0] d_sample_idx;
    logic              d_layer_sel;
    logic [D_NB_W-1:0] d_neuron_base;
    logic [D_IN_W-1:0] d_in_idx;
    logic              d_mac_clr, d_mac_en, d_act_wr;
    logic [D_SC_W-1:0] d_score_idx;
    logic signed [SW-1:0] d_score;
    logic [7:0]        d_result;
    logic              d_batch_done, d_done, d_busy;

    int s_scores [S_NS][S_NO];
    int d_scores [D_NS][D_NO];

    always_comb begin
        s_score = '0;
        if (int'(s_sample_idx) < S_NS && int'(s_score_idx) < S_NO)
            s_score = SW'(s_scores[int'(s_sample_idx)][int'(s_score_idx)]);
    end

    always_comb begin
        d_score = '0;
        if (int'(d_sample_idx) < D_NS && int'(d_score_idx) < D_NO)
            d_score = SW'(d_scores[int'(d_sample_idx)][int'(d_score_idx)]);
    end

    nn_sequencer #(
        .NUM_SAMPLES(S_NS), .NUM_INPUTS(S_NI), .NUM_HIDDEN(S_NH),
        .NUM_OUTPUTS(S_NO), .PE_COUNT(S_PE), .SCORE_W(SW)
    ) dut_s (
        .clk(clk), .rst(rst), .start(s_start),
        .sample_idx(s_sample_idx), .layer_sel(s_layer_sel),
        .neuron_base(s_neuron_base), .in_idx(s_in_idx),
        .mac_clr(s_mac_clr), .mac_en(s_mac_en), .act_wr(s_act_wr),
        .score_idx(s_score_idx), .score(s_score), .result(s_result),
        .batch_done(s_batch_done), .done(s_done), .busy(s_busy)
    );

    nn_sequencer #(
        .NUM_SAMPLES(D_NS), .NUM_INPUTS(D_NI), .NUM_HIDDEN(D_NH),
        .NUM_OUTPUTS(D_NO), .PE_COUNT(D_PE), .SCORE_W(SW)
    ) dut_d (
        .clk(clk), .rst(rst), .start(d_start),
        .sample_idx(d_sample_idx), .layer_sel(d_layer_sel),
        .neuron_base(d_neuron_base), .in_idx(d_in_idx),
        .mac_clr(d_mac_clr), .mac_en(d_mac_en), .act_wr(d_act_wr),
        .score_idx(d_score_idx), .score(d_score), .result(d_result),
        .batch_done(d_batch_done), .done(d_done), .busy(d_busy)
    );

    // Reference schedule for one sample of the small configuration.
    // kind: 0 = clear, 1 = mac, 2 = write, 3 = argmax read, 4 = report
    typedef struct {
        int kind;
        int layer;
        int base;
        int idx;
    } cyc_t;

    cyc_t trace[$];

    task automatic push_cyc(input int kind, input int layer, input int base, input int idx);
        cyc_t c;
        c.kind = kind; c.layer = layer; c.base = base; c.idx = idx;
        trace.push_back(c);
    endtask

    task automatic build_trace();
        trace.delete();
        for (int b = 0; b < S_NH; b += S_PE) begin
            push_cyc(0, 0, b, 0);
            for (int i = 0; i < S_NI; i++) push_cyc(1, 0, b, i);
            push_cyc(2, 0, b, 0);
        end
        push_cyc(0, 1, 0, 0);
        for (int i = 0; i < S_NH; i++) push_cyc(1, 1, 0, i);
        push_cyc(2, 1, 0, 0);
        for (int k = 0; k < S_NO; k++) push_cyc(3, 0, 0, k);
        push_cyc(4, 0, 0, 0);
    endtask

    function automatic int argmax_q(input int v[$]);
        int best = 0;
        for (int k = 1; k < v.size(); k++)
            if (v[k] > v[best]) best = k;
        return best;
    endfunction

    function automatic int model_small(input int s);
        int v[$];
        for (int k = 0; k < S_NO; k++) v.push_back(s_scores[s][k]);
        return argmax_q(v);
    endfunction

    function automatic int model_default(input int s);
        int v[$];
        for (int k = 0; k < D_NO; k++) v.push_back(d_scores[s][k]);
        return argmax_q(v);
    endfunction

    // Full two-sample run on the small instance; optional stray start on cycle 'poke'.
    task automatic run_small(input logic done_at_idle, input int poke);
        int k;
        logic [4:0] exp_str, obs_str;
        @(negedge clk);
        vectors++;
        if ({s_busy, s_done} !== {1'b0, done_at_idle}) begin
            miscompares++;
            $display("FAIL idle_busy_done: got %b%b expected %b%b", s_busy, s_done, 1'b0, done_at_idle);
        end
        s_start = 1'b1;
        k = 0;
        for (int s = 0; s < S_NS; s++) begin
            foreach (trace[j]) begin
                @(negedge clk);
                k++;
                s_start = (k == poke);
                exp_str = {trace[j].kind == 0, trace[j].kind == 1, trace[j].kind == 2,
                           trace[j].kind == 4, 1'b1};
                obs_str = {s_mac_clr, s_mac_en, s_act_wr, s_batch_done, s_busy};
                vectors++;
                if (obs_str !== exp_str) begin
                    miscompares++;
                    $display("FAIL strobes cycle %0d: got %b expected %b", k, obs_str, exp_str);
                end
                vectors++;
                if (s_sample_idx !== S_SA_W'(s)) begin
                    miscompares++;
                    $display("FAIL sample_idx cycle %0d: got %0d expected %0d", k, s_sample_idx, s);
                end
                if (trace[j].kind <= 2) begin
                    vectors++;
                    if ({s_layer_sel, s_neuron_base} !== {1'(trace[j].layer), S_NB_W'(trace[j].base)}) begin
                        miscompares++;
                        $display("FAIL layer_base cycle %0d: got %0d/%0d expected %0d/%0d",
                                 k, s_layer_sel, s_neuron_base, trace[j].layer, trace[j].base);
                    end
                end
                if (trace[j].kind == 1) begin
                    vectors++;
                    if (s_in_idx !== S_IN_W'(trace[j].idx)) begin
                        miscompares++;
                        $display("FAIL in_idx cycle %0d: got %0d expected %0d", k, s_in_idx, trace[j].idx);
                    end
                end
                if (trace[j].kind == 3) begin
                    vectors++;
                    if (s_score_idx !== S_SC_W'(trace[j].idx)) begin
                        miscompares++;
                        $display("FAIL score_idx cycle %0d: got %0d expected %0d", k, s_score_idx, trace[j].idx);
                    end
                end
                if (trace[j].kind == 4) begin
                    vectors++;
                    if (s_result !== 8'(model_small(s))) begin
                        miscompares++;
                        $display("FAIL result sample %0d: got %0d expected %0d", s, s_result, model_small(s));
                    end
                end
                vectors++;
                if (s_done !== (trace[j].kind == 4 && s == S_NS - 1)) begin
                    miscompares++;
                    $display("FAIL done cycle %0d: got %b", k, s_done);
                end
            end
        end
        @(negedge clk);
        s_start = 1'b0;
        vectors++;
        if ({s_busy, s_done, s_mac_clr, s_batch_done} !== 4'b0100) begin
            miscompares++;
            $display("FAIL after_run busy/done/clr/bd: got %b expected 0100",
                     {s_busy, s_done, s_mac_clr, s_batch_done});
        end
    endtask

    task automatic set_small(input int a0, input int a1, input int a2,
                             input int b0, input int b1, input int b2);
        s_scores[0][0] = a0; s_scores[0][1] = a1; s_scores[0][2] = a2;
        s_scores[1][0] = b0; s_scores[1][1] = b1; s_scores[1][2] = b2;
    endtask

    task automatic randomize_small();
        for (int s = 0; s < S_NS; s++)
            for (int k = 0; k < S_NO; k++)
                s_scores[s][k] = int'($urandom_range(0, 6)) - 3;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({s_sample_idx, s_layer_sel, s_neuron_base, s_in_idx, s_mac_clr, s_mac_en, s_act_wr,
             s_score_idx, s_result, s_batch_done, s_done, s_busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_small: outputs not all zero");
        end
        vectors++;
        if ({d_sample_idx, d_layer_sel, d_neuron_base, d_in_idx, d_mac_clr, d_mac_en, d_act_wr,
             d_score_idx, d_result, d_batch_done, d_done, d_busy} !== '0) begin
            miscompares++;
            $display("FAIL reset_default: outputs not all zero");
        end
        rst = 1'b1;
    endtask

    task automatic test_pass_sequence();
        set_small(-5, 7, 7, 3, -2, 3);
        run_small(1'b0, -1);
    endtask

    task automatic test_signed_argmax();
        set_small(-9, -3, -8, 0, 0, 0);
        run_small(1'b1, -1);
    endtask

    task automatic test_start_ignored();
        randomize_small();
        run_small(1'b1, 9);
        randomize_small();
        run_small(1'b1, 21);
    endtask

    task automatic test_reset_abort();
        randomize_small();
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        repeat (22) @(negedge clk);
        vectors++;
        if ({s_mac_en, s_sample_idx} !== {1'b1, S_SA_W'(1)}) begin
            miscompares++;
            $display("FAIL abort_precondition: mac_en/sample got %b/%0d expected 1/1", s_mac_en, s_sample_idx);
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({s_sample_idx, s_layer_sel, s_neuron_base, s_in_idx, s_mac_clr, s_mac_en, s_act_wr,
             s_score_idx, s_result, s_batch_done, s_done, s_busy} !== '0) begin
            miscompares++;
            $display("FAIL abort_outputs: not zero during reset, busy=%b mac_en=%b", s_busy, s_mac_en);
        end
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if ({s_batch_done, s_done, s_busy} !== 3'b000) begin
                miscompares++;
                $display("FAIL abort_hold: bd/done/busy got %b expected 000", {s_batch_done, s_done, s_busy});
            end
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if ({s_batch_done, s_done, s_busy} !== 3'b000) begin
                miscompares++;
                $display("FAIL abort_no_restart: bd/done/busy got %b expected 000", {s_batch_done, s_done, s_busy});
            end
        end
        run_small(1'b0, -1);
    endtask

    task automatic test_random_samples();
        for (int r = 0; r < 3; r++) begin
            randomize_small();
            run_small(1'b1, -1);
        end
    endtask

    task automatic test_default_batch();
        int p, lat, limit, nbd, nmac, nwr;
        p     = (D_NH + D_PE - 1) / D_PE;
        lat   = p * (D_NI + 2) + (D_NH + 2) + D_NO + 1;
        limit = D_NS * lat + 4;
        nbd = 0; nmac = 0; nwr = 0;
        for (int s = 0; s < D_NS; s++)
            for (int k = 0; k < D_NO; k++)
                d_scores[s][k] = (k % 3 == 0) ? int'($urandom_range(0, 4)) - 2
                                              : int'($urandom_range(0, 65535)) - 32768;
        @(negedge clk);
        d_start = 1'b1;
        for (int cyc = 1; cyc <= limit; cyc++) begin
            @(negedge clk);
            d_start = 1'b0;
            if (d_mac_en) nmac++;
            if (d_act_wr) nwr++;
            if (d_batch_done) begin
                vectors++;
                if (cyc != lat * (nbd + 1)) begin
                    miscompares++;
                    $display("FAIL default_bd_cycle %0d: got cycle %0d expected %0d", nbd, cyc, lat * (nbd + 1));
                end
                vectors++;
                if (nbd >= D_NS) begin
                    miscompares++;
                    $display("FAIL default_extra_bd: pulse %0d at cycle %0d", nbd, cyc);
                end else if (d_result !== 8'(model_default(nbd))) begin
                    miscompares++;
                    $display("FAIL default_result %0d: got %0d expected %0d", nbd, d_result, model_default(nbd));
                end
                vectors++;
                if (d_done !== (nbd == D_NS - 1)) begin
                    miscompares++;
                    $display("FAIL default_done_with_bd %0d: got %b", nbd, d_done);
                end
                nbd++;
            end
            if (cyc == D_NS * lat + 1) begin
                vectors++;
                if ({d_busy, d_done} !== 2'b01) begin
                    miscompares++;
                    $display("FAIL default_end busy/done: got %b%b expected 01", d_busy, d_done);
                end
            end
        end
        vectors++;
        if (nbd != D_NS) begin
            miscompares++;
            $display("FAIL default_bd_count: got %0d expected %0d", nbd, D_NS);
        end
        vectors++;
        if (nmac != D_NS * (p * D_NI + D_NH)) begin
            miscompares++;
            $display("FAIL default_mac_count: got %0d expected %0d", nmac, D_NS * (p * D_NI + D_NH));
        end
        vectors++;
        if (nwr != D_NS * (p + 1)) begin
            miscompares++;
            $display("FAIL default_wr_count: got %0d expected %0d", nwr, D_NS * (p + 1));
        end
    endtask

    initial begin
        build_trace();
        test_reset();
        test_pass_sequence();
        test_signed_argmax();
        test_start_ignored();
        test_reset_abort();
        test_random_samples();
        test_default_batch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
